alu_flag_cond_stage: RTL
========================

// Module: alu_flag_cond_stage
// PURPOSE
//  Execute/writeback boundary stage directly downstream of the ALU.
//  - Holds the architectural NZCV flag register.
//  - Evaluates each instruction's 4-bit condition code against the current flags.
//  - Squashes the side effects of failed instructions.
//  - Registers the result into a 2-entry valid/ready skid buffer that feeds writeback.
// PARAMETERS
//  DATA_W     32  result width; must match the ALU result width
//  REGADDR_W  4   destination register address width
//  CNT_W      16  squash counter width (only used with COND_STATS_EN)
// PORTS
//  clk           in   1          single clock, rising edge
//  reset         in   1          synchronous, active-high
//  in_valid      in   1          ALU result and controls are valid this cycle
//  in_ready      out  1          stage can accept; handshake occurs on in_valid&in_ready
//  ALUResult     in   DATA_W     ALU result
//  Negative      in   1          ALU N output
//  Zero          in   1          ALU Z output
//  Carry         in   1          ALU C output
//  Overflow      in   1          ALU V output
//  Cond          in   4          condition field
//  FlagWrite     in   2          [1]: update N,Z; [0]: update C,V
//  RegWrite      in   1          raw register write enable
//  MemWrite      in   1          raw memory write enable
//  PCSrc         in   1          raw branch/PC write
//  WA3           in   REGADDR_W  destination register address
//  out_valid     out  1          head entry is valid
//  out_ready     in   1          consumer accepts; pops on out_valid&out_ready
//  out_result    out  DATA_W     head entry result
//  out_wa3       out  REGADDR_W  head entry destination address
//  out_regwrite  out  1          RegWrite&CondEx of head entry
//  out_memwrite  out  1          MemWrite&CondEx of head entry
//  out_pcsrc     out  1          PCSrc&CondEx of head entry
//  out_condex    out  1          CondEx of head entry
//  Flags         out  4          architectural {N,Z,C,V}
//  squash_count  out  CNT_W      present only with COND_STATS_EN
// BEHAVIOUR
//  Reset (reset=1 at a rising edge):
//   - Flags=0000, buffer EMPTY, out_valid=0, all out_* fields=0, squash_count=0.
//   - in_ready=0 while reset is high.
//   - Reset mid-operation discards all buffered entries.
//   - A handshake in the reset cycle is ignored: no flag update, no capture.
//  CondEx (combinational, uses the registered Flags before this instruction's update):
//   - 0 EQ Z | 1 NE !Z | 2 CS C | 3 CC !C | 4 MI N | 5 PL !N | 6 VS V | 7 VC !V
//   - 8 HI C&!Z | 9 LS !C|Z | A GE N==V | B LT N!=V | C GT !Z&(N==V)
//   - D LE Z|(N!=V) | E AL 1 | F 0 (reserved, never executes)
//  Flag update: only on an accepted handshake with CondEx=1.
//   - FlagWrite[1] loads {N,Z}; FlagWrite[0] loads {C,V}; both may be set.
//   - New flags are visible to the next accepted instruction on the following cycle.
//   - Flags never change when CondEx=0, when in_valid=0, or when in_ready=0.
//  Buffer FSM, states EMPTY/ONE/TWO; in_ready = (state!=TWO) & !reset.
//   - EMPTY: accept -> ONE.
//   - ONE:
//     - accept without pop -> TWO.
//     - pop without accept -> EMPTY.
//     - accept and pop in the same cycle -> stays ONE; the new entry becomes head.
//   - TWO:
//     - pop -> ONE; the skid entry moves to head.
//     - no accept is possible.
//  Ordering and outputs:
//   - Strict FIFO order.
//   - Latency is 1 cycle: accept at edge k makes out_valid=1 after edge k when the buffer was EMPTY.
//   - out_* fields hold stable while out_valid=1 and out_ready=0.
//   - out_* fields are 0 when out_valid=0.
//   - Squashed instructions (CondEx=0) still occupy a slot: result and wa3 are passed
//     through with all enables low, which keeps the instruction count intact.
// CONFIGURATION
//  COND_STATS_EN defined:
//   - squash_count increments by 1 on every accepted handshake with CondEx=0.
//   - Saturates at 2^CNT_W-1.
//   - Cleared only by reset.
//  COND_STATS_EN undefined:
//   - squash_count port and its counter logic are absent.
//   - All other behaviour is identical.
// TESTING
//  1. Reset, then one accept: ALUResult=5, Cond=E, RegWrite=1, FlagWrite=11, N/Z/C/V=0010,
//     out_ready=1.
//     -> Next cycle: out_valid=1, out_result=5, out_regwrite=1, Flags=0010.
//  2. Flags=0100 (Z=1). Back-to-back accepts:
//     - EQ, FlagWrite=11, ALU flags 0000 -> out_condex=1; Flags become 0000.
//     - Then EQ -> out_condex=0, out_regwrite=0, Flags stay 0000.
//  3. Hold out_ready=0 and issue 3 valid instructions.
//     -> First two accepted, in_ready=0 on the third (state TWO).
//     -> Raise out_ready: results pop in order; the third is accepted the cycle after the first pop.
//  4. Cond=F with RegWrite=MemWrite=PCSrc=1 and FlagWrite=11.
//     -> out_condex=0, all out enables 0, Flags unchanged.
//     -> squash_count +1 when COND_STATS_EN is defined.
//  5. Buffer in TWO, assert reset for 1 cycle while in_valid=1.
//     -> out_valid=0, Flags=0000, no capture; in_ready=1 the cycle after reset deasserts.
//  6. Flags=1001 (N=1, V=1): GE, GT, LT, LE.
//     -> CondEx = 1, 1, 0, 0.
//     -> With Flags=0110: HI=0, LS=1.

Source files
------------

// File: rtl/alu_flag_cond_stage.sv
// alu_flag_cond_stage: execute/writeback boundary stage after the ALU.
// Holds NZCV flags, evaluates the condition code against them, squashes
// failed instructions and registers results into a 2-entry skid buffer.
// Optional feature macro: COND_STATS_EN (adds squash_count port and counter).
module alu_flag_cond_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned REGADDR_W = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    ALUResult,
  input  logic                 Negative,
  input  logic                 Zero,
  input  logic                 Carry,
  input  logic                 Overflow,
  input  logic [3:0]           Cond,
  input  logic [1:0]           FlagWrite,
  input  logic                 RegWrite,
  input  logic                 MemWrite,
  input  logic                 PCSrc,
  input  logic [REGADDR_W-1:0] WA3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_result,
  output logic [REGADDR_W-1:0] out_wa3,
  output logic                 out_regwrite,
  output logic                 out_memwrite,
  output logic                 out_pcsrc,
  output logic                 out_condex,
  output logic [3:0]           Flags
`ifdef COND_STATS_EN
  ,
  output logic [CNT_W-1:0]     squash_count
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0]    result;
    logic [REGADDR_W-1:0] wa3;
    logic                 regwrite;
    logic                 memwrite;
    logic                 pcsrc;
    logic                 condex;
  } entry_t;

  state_e     state_q, state_d;
  entry_t     head_q, head_d;
  entry_t     skid_q, skid_d;
  logic [3:0] flags_q, flags_d;

  logic   cond_ex_c;
  logic   accept_c;
  logic   pop_c;
  entry_t new_entry_c;
  logic   n_c, z_c, c_c, v_c;

  assign n_c = flags_q[3];
  assign z_c = flags_q[2];
  assign c_c = flags_q[1];
  assign v_c = flags_q[0];

  // Condition evaluation against the flags as they stand before this instruction
  always_comb begin
    cond_ex_c = 1'b0;
    unique case (Cond)
      4'h0: cond_ex_c = z_c;
      4'h1: cond_ex_c = ~z_c;
      4'h2: cond_ex_c = c_c;
      4'h3: cond_ex_c = ~c_c;
      4'h4: cond_ex_c = n_c;
      4'h5: cond_ex_c = ~n_c;
      4'h6: cond_ex_c = v_c;
      4'h7: cond_ex_c = ~v_c;
      4'h8: cond_ex_c = c_c & ~z_c;
      4'h9: cond_ex_c = ~c_c | z_c;
      4'hA: cond_ex_c = (n_c == v_c);
      4'hB: cond_ex_c = (n_c != v_c);
      4'hC: cond_ex_c = ~z_c & (n_c == v_c);
      4'hD: cond_ex_c = z_c | (n_c != v_c);
      4'hE: cond_ex_c = 1'b1;
      4'hF: cond_ex_c = 1'b0;
      default: cond_ex_c = 1'b0;
    endcase
  end

  // Handshakes; in_ready is forced low while reset is asserted
  assign in_ready = (state_q != ST_TWO) & ~reset;
  assign accept_c = in_valid & in_ready;
  assign pop_c    = (state_q != ST_EMPTY) & out_ready;

  // Incoming entry with side-effect enables gated by the condition result
  always_comb begin
    new_entry_c          = '0;
    new_entry_c.result   = ALUResult;
    new_entry_c.wa3      = WA3;
    new_entry_c.regwrite = RegWrite & cond_ex_c;
    new_entry_c.memwrite = MemWrite & cond_ex_c;
    new_entry_c.pcsrc    = PCSrc & cond_ex_c;
    new_entry_c.condex   = cond_ex_c;
  end

  // Skid-buffer next state and entry movement; empty slots are kept at zero
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept_c) begin
          state_d = ST_ONE;
          head_d  = new_entry_c;
        end
      end
      ST_ONE: begin
        if (accept_c && pop_c) begin
          head_d = new_entry_c;
        end else if (accept_c) begin
          state_d = ST_TWO;
          skid_d  = new_entry_c;
        end else if (pop_c) begin
          state_d = ST_EMPTY;
          head_d  = '0;
        end
      end
      ST_TWO: begin
        if (pop_c) begin
          state_d = ST_ONE;
          head_d  = skid_q;
          skid_d  = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        head_d  = '0;
        skid_d  = '0;
      end
    endcase
  end

  // Flag update only for accepted instructions whose condition passed
  always_comb begin
    flags_d = flags_q;
    if (accept_c && cond_ex_c) begin
      if (FlagWrite[1]) flags_d[3:2] = {Negative, Zero};
      if (FlagWrite[0]) flags_d[1:0] = {Carry, Overflow};
    end
  end

  // State, buffer and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      flags_q <= flags_d;
    end
  end

  assign out_valid    = (state_q != ST_EMPTY);
  assign out_result   = head_q.result;
  assign out_wa3      = head_q.wa3;
  assign out_regwrite = head_q.regwrite;
  assign out_memwrite = head_q.memwrite;
  assign out_pcsrc    = head_q.pcsrc;
  assign out_condex   = head_q.condex;
  assign Flags        = flags_q;

`ifdef COND_STATS_EN
  logic [CNT_W-1:0] squash_count_q, squash_count_d;

  // Saturating count of accepted instructions that failed their condition
  always_comb begin
    squash_count_d = squash_count_q;
    if (accept_c && !cond_ex_c && (squash_count_q != {CNT_W{1'b1}})) begin
      squash_count_d = squash_count_q + CNT_W'(1);
    end
  end

  // Squash counter register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) squash_count_q <= '0;
    else       squash_count_q <= squash_count_d;
  end

  assign squash_count = squash_count_q;
`else
  // Counter width is still validated so a bad configuration is caught early
  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end
`endif

endmodule
